// File: rtl/i2s_tx_serializer_if.sv
// Upstream sample-pair handshake for the I2S transmitter.
// master = decode/volume path driving pairs, slave = serializer.
interface i2s_tx_serializer_if #(
  parameter int SAMPLE_W = 24
);
  logic [SAMPLE_W-1:0] sample_left;
  logic [SAMPLE_W-1:0] sample_right;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_left, sample_right, sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left, sample_right, sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Parallel-to-I2S transmitter (Philips format, MSB one BCK after the WS edge).
// Holds one stereo pair in a buffer; the pair is moved into the shifters at
// each frame load, otherwise the frame carries zeros and flags underrun.
// Optional: define TOI2S_TX_MUTE_EN to add a `mute` input sampled at frame load.
module i2s_tx_serializer #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int BCK_DIV  = 2
) (
  input  logic clk,
  input  logic reset,
  i2s_tx_serializer_if.slave bus,
`ifdef TOI2S_TX_MUTE_EN
  input  logic mute,
`endif
  output logic i2s_bck,
  output logic i2s_ws,
  output logic i2s_d0,
  output logic frame_start,
  output logic underrun
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  localparam logic [BW-1:0] LAST_B = BW'(FRAME - 1);
  localparam logic [BW-1:0] SLOT_B = BW'(SLOT_W);
  localparam logic [BW-1:0] LLSB_B = BW'(SAMPLE_W);
  localparam logic [BW-1:0] RMSB_B = BW'(SLOT_W + 1);
  localparam logic [BW-1:0] RLSB_B = BW'(SLOT_W + SAMPLE_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       nxt_b;
  logic [SAMPLE_W-1:0] sh_l;
  logic [SAMPLE_W-1:0] sh_r;
  pair_t               buf_q;
  logic                buf_full;
  logic                fall_adv;
  logic                load;
  logic                load_zero;

  // BCK falls on the terminal divider count while BCK is high
  assign fall_adv = (div_cnt == DIV_LAST) && i2s_bck;
  assign nxt_b    = (bit_cnt == LAST_B) ? '0 : bit_cnt + 1'b1;
  assign load     = fall_adv && (nxt_b == '0);

  assign bus.sample_ready = !buf_full;

`ifdef TOI2S_TX_MUTE_EN
  assign load_zero = mute;
`else
  assign load_zero = 1'b0;
`endif

  // BCK divider: toggle bck every BCK_DIV clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      i2s_bck <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      i2s_bck <= ~i2s_bck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // One-entry pair buffer; a load frees it, an accept can only hit an empty buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_q    <= '0;
    end else if (load && buf_full) begin
      buf_full <= 1'b0;
    end else if (bus.sample_valid && !buf_full) begin
      buf_full <= 1'b1;
      buf_q    <= '{left: bus.sample_left, right: bus.sample_right};
    end
  end

  // Frame sequencer: ws/d0 advance on BCK falling edges, shifters load at bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= LAST_B;
      i2s_ws      <= 1'b1;
      i2s_d0      <= 1'b0;
      sh_l        <= '0;
      sh_r        <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall_adv) begin
        bit_cnt <= nxt_b;
        i2s_ws  <= (nxt_b >= SLOT_B);
        i2s_d0  <= 1'b0;
        if (nxt_b == '0) begin
          // bit 0 is the delay bit, so d0 stays 0 while the shifters load
          frame_start <= 1'b1;
          underrun    <= !buf_full;
          if (buf_full && !load_zero) begin
            sh_l <= buf_q.left;
            sh_r <= buf_q.right;
          end else begin
            sh_l <= '0;
            sh_r <= '0;
          end
        end else if (nxt_b <= LLSB_B) begin
          i2s_d0 <= sh_l[SAMPLE_W-1];
          sh_l   <= {sh_l[SAMPLE_W-2:0], 1'b0};
        end else if ((nxt_b >= RMSB_B) && (nxt_b <= RLSB_B)) begin
          i2s_d0 <= sh_r[SAMPLE_W-1];
          sh_r   <= {sh_r[SAMPLE_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: frame-level reference model feeds a queue of
// expected frames; a separate monitor rebuilds each frame from d0/ws at BCK
// rising edges and compares against the queue.
module tb_i2s_tx_serializer;
  localparam int SW    = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 2;
  localparam int FRAME = 2 * SLOT;
  localparam int FCLK  = 2 * DIV * FRAME;
  localparam int FIRST = 2 * DIV;
  localparam logic [FRAME-1:0] WS_EXP = {{SLOT{1'b1}}, {SLOT{1'b0}}};

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    bit            und;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i2s_bck, i2s_ws, i2s_d0, frame_start, underrun;
`ifdef TOI2S_TX_MUTE_EN
  logic mute = 1'b0;
`endif

  i2s_tx_serializer_if #(.SAMPLE_W(SW)) sif ();

  i2s_tx_serializer #(.SAMPLE_W(SW), .SLOT_W(SLOT), .BCK_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (sif),
`ifdef TOI2S_TX_MUTE_EN
    .mute        (mute),
`endif
    .i2s_bck     (i2s_bck),
    .i2s_ws      (i2s_ws),
    .i2s_d0      (i2s_d0),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  // reference model state
  int   cyc = 0;
  bit   m_full = 0, m_load = 0, m_und = 0, m_acc = 0;
  logic [SW-1:0] m_bl, m_br;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Expected d0 pattern of one frame, index = bit position within the frame
  function automatic logic [FRAME-1:0] frame_bits(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [FRAME-1:0] v;
    v = '0;
    for (int b = 1; b <= SW; b++) begin
      v[b]        = l[SW-b];
      v[SLOT + b] = r[SW-b];
    end
    return v;
  endfunction

  function automatic bit next_is_load();
    return ((cyc + 1) >= FIRST) && (((cyc + 1 - FIRST) % FCLK) == 0);
  endfunction

  task automatic model_reset();
    cyc = 0; m_full = 0; m_load = 0; m_und = 0; m_acc = 0;
    exp_q.delete();
  endtask

  // One clk edge of the spec-level model: frame loads every FCLK clk,
  // starting FIRST clk after reset release
  task automatic model_step();
    bit   full_before;
    exp_t f;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    full_before = m_full;
    m_load = 0; m_und = 0; m_acc = 0;
    if (cyc >= FIRST && ((cyc - FIRST) % FCLK) == 0) begin
      m_load = 1;
      m_und  = !full_before;
      f.und  = !full_before;
      f.l    = full_before ? m_bl : '0;
      f.r    = full_before ? m_br : '0;
`ifdef TOI2S_TX_MUTE_EN
      if (mute) begin
        f.l = '0;
        f.r = '0;
      end
`endif
      exp_q.push_back(f);
      m_full = 0;
    end
    if (sif.sample_valid && !full_before) begin
      m_bl = sif.sample_left;
      m_br = sif.sample_right;
      m_full = 1;
      m_acc  = 1;
    end
  endtask

  task automatic check_cycle();
    chk("bck", i2s_bck, (cyc / DIV) % 2);
    chk("sample_ready", sif.sample_ready, !m_full);
    chk("frame_start", frame_start, m_load);
    chk("underrun", underrun, m_und);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 3 * FCLK);
    if (!m_acc) fail_now("accept_timeout");
    sif.sample_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    sif.sample_left  = l;
    sif.sample_right = r;
    sif.sample_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_next_load();
    int n = 0;
    while (!next_is_load() && n < 2 * FCLK) begin
      tick();
      n++;
    end
    if (!next_is_load()) fail_now("load_wait_timeout");
  endtask

  // Monitor: rebuild each frame from the pins and compare with the queue head
  initial begin : monitor
    int idx;
    bit col, prev_bck;
    logic [FRAME-1:0] got_d, got_ws;
    exp_t e;
    idx = 0; col = 0; prev_bck = 0; got_d = '0; got_ws = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        col = 0;
        idx = 0;
      end else if (frame_start) begin
        if (exp_q.size() == 0) begin
          fail_now("frame_unexpected");
          col = 0;
        end else begin
          chk("frame_underrun", underrun, exp_q[0].und);
          col = 1;
          idx = 0;
        end
      end else if (col && i2s_bck && !prev_bck) begin
        got_d[idx]  = i2s_d0;
        got_ws[idx] = i2s_ws;
        idx++;
        if (idx == FRAME) begin
          col = 0;
          if (exp_q.size() == 0) fail_now("frame_queue_empty");
          else begin
            e = exp_q.pop_front();
            chk("frame_d0", got_d, frame_bits(e.l, e.r));
            chk("frame_ws", got_ws, WS_EXP);
          end
        end
      end
      prev_bck = i2s_bck;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    sif.sample_left  = '0;
    sif.sample_right = '0;
    sif.sample_valid = 1'b0;

    // A: reset state, then idle frames (underrun zeros)
    tick();
    tick();
    chk("rst_ws", i2s_ws, 1);
    chk("rst_d0", i2s_d0, 0);
    reset = 1'b0;
    run(FCLK + 40);

    // B: pair presented before the first load
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    sif.sample_left  = 24'h800001;
    sif.sample_right = 24'h7FFFFF;
    sif.sample_valid = 1'b1;
    reset = 1'b0;
    wait_accept();
    run(2 * FCLK);

    // C: back-to-back stream with valid held high
    sif.sample_left  = SW'($urandom);
    sif.sample_right = SW'($urandom);
    sif.sample_valid = 1'b1;
    for (int i = 0; i < 8 * FCLK; i++) begin
      tick();
      if (m_acc) begin
        sif.sample_left  = SW'($urandom);
        sif.sample_right = SW'($urandom);
      end
    end
    sif.sample_valid = 1'b0;

    // D: valid rises in the same clk as a load with an empty buffer
    wait_next_load();
    tick();
    wait_next_load();
    sif.sample_left  = SW'($urandom);
    sif.sample_right = SW'($urandom);
    sif.sample_valid = 1'b1;
    tick();
    sif.sample_valid = 1'b0;
    run(2 * FCLK);

    // E: asynchronous reset at bit_cnt=40 with a pair buffered
    wait_next_load();
    tick();
    send_pair(SW'($urandom), SW'($urandom));
    begin
      int n = 0;
      while (((cyc - FIRST) % FCLK) != 4 * 40 + 1 && n < FCLK) begin
        tick();
        n++;
      end
    end
    chk("pre_rst_buffered", sif.sample_ready, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_bck", i2s_bck, 0);
    chk("async_rst_ws", i2s_ws, 1);
    chk("async_rst_d0", i2s_d0, 0);
    chk("async_rst_ready", sif.sample_ready, 1);
    chk("async_rst_fs", frame_start, 0);
    chk("async_rst_und", underrun, 0);
    tick();
    tick();
    reset = 1'b0;
    run(2 * FCLK + 20);

`ifdef TOI2S_TX_MUTE_EN
    // Mute with a pair buffered: zeros, no underrun, buffer consumed
    wait_next_load();
    tick();
    send_pair(24'h123456, 24'h123456);
    mute = 1'b1;
    wait_next_load();
    tick();
    mute = 1'b0;
    run(FCLK + 20);
`endif

    // F: random valid with gaps (and random mute when present)
    for (int i = 0; i < 6 * FCLK; i++) begin
      tick();
      if (!sif.sample_valid || m_acc) begin
        sif.sample_valid = ($urandom_range(0, 3) == 0);
        sif.sample_left  = SW'($urandom);
        sif.sample_right = SW'($urandom);
      end
`ifdef TOI2S_TX_MUTE_EN
      mute = ($urandom_range(0, 2) == 0);
`endif
    end
    sif.sample_valid = 1'b0;
    run(FCLK);

    chk("queue_drained", (exp_q.size() <= 1), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
